// File: rtl/ex_pkg.sv
// ex_pkg: shared opcodes, ALU op codes, control bundle and condition selects for the execute stage
package ex_pkg;
  localparam logic [4:0] OPC_ADDI  = 5'b01000;
  localparam logic [4:0] OPC_SUBI  = 5'b01001;
  localparam logic [4:0] OPC_XORI  = 5'b01010;
  localparam logic [4:0] OPC_ANDNI = 5'b01011;
  localparam logic [4:0] OPC_BEQZ  = 5'b01100;
  localparam logic [4:0] OPC_BNEZ  = 5'b01101;
  localparam logic [4:0] OPC_BLTZ  = 5'b01110;
  localparam logic [4:0] OPC_BGEZ  = 5'b01111;
  localparam logic [4:0] OPC_ROLI  = 5'b10100;
  localparam logic [4:0] OPC_SLLI  = 5'b10101;
  localparam logic [4:0] OPC_RORI  = 5'b10110;
  localparam logic [4:0] OPC_SRLI  = 5'b10111;
  localparam logic [4:0] OPC_RSHF  = 5'b11010;
  localparam logic [4:0] OPC_RALU  = 5'b11011;
  localparam logic [4:0] OPC_SEQ   = 5'b11100;
  localparam logic [4:0] OPC_SLT   = 5'b11101;
  localparam logic [4:0] OPC_SLE   = 5'b11110;
  localparam logic [4:0] OPC_SCO   = 5'b11111;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;
  localparam logic [2:0] ALU_ROL = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_ROR = 3'b010;
  localparam logic [2:0] ALU_SRL = 3'b011;
  typedef enum logic [3:0] {
    C_NONE, C_SEQ, C_SLT, C_SLE, C_SCO, C_BEQZ, C_BNEZ, C_BLTZ, C_BGEZ
  } cond_e;
  typedef struct packed {
    logic [2:0] op;
    logic       inva;
    logic       invb;
    logic       cin;
    logic       sign;
    logic       bzero;
    logic       arith;
  } ctrl_t;
  function automatic logic is_set(input cond_e c);
    return c inside {C_SEQ, C_SLT, C_SLE, C_SCO};
  endfunction
  function automatic logic is_br(input cond_e c);
    return c inside {C_BEQZ, C_BNEZ, C_BLTZ, C_BGEZ};
  endfunction
endpackage

// File: rtl/ex_alu_decode.sv
// ex_alu_decode: combinational opcode/func -> ALU control bundle and condition select
//  opcode, func : instruction fields
//  ctrl         : ALU control (op, inva, invb, cin, sign, bzero) plus arith (ADD/SUB overflow tracking)
//  cond_sel     : which flag combination forms the set/branch condition
module ex_alu_decode
  import ex_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [1:0] func,
  output ctrl_t      ctrl,
  output cond_e      cond_sel
);
  always_comb begin
    ctrl = '{op: ALU_ADD, inva: 1'b0, invb: 1'b0, cin: 1'b0, sign: 1'b1, bzero: 1'b0, arith: 1'b0};
    cond_sel = C_NONE;
    case (opcode)
      OPC_ADDI: ctrl.arith = 1'b1;
      OPC_SUBI: {ctrl.inva, ctrl.cin, ctrl.arith} = 3'b111;
      OPC_XORI: ctrl.op = ALU_XOR;
      OPC_ANDNI: {ctrl.op, ctrl.invb} = {ALU_AND, 1'b1};
      OPC_ROLI, OPC_SLLI, OPC_RORI, OPC_SRLI: {ctrl.op, ctrl.sign} = {1'b0, opcode[1:0], 1'b0};
      OPC_RSHF: {ctrl.op, ctrl.sign} = {1'b0, func, 1'b0};
      OPC_RALU: begin
        case (func)
          2'b00: ctrl.arith = 1'b1;
          2'b01: {ctrl.inva, ctrl.cin, ctrl.arith} = 3'b111;
          2'b10: ctrl.op = ALU_XOR;
          default: {ctrl.op, ctrl.invb} = {ALU_AND, 1'b1};
        endcase
      end
      // compares compute Rt - Rs as a signed subtraction
      OPC_SEQ: begin
        {ctrl.inva, ctrl.cin} = 2'b11;
        cond_sel = C_SEQ;
      end
      OPC_SLT: begin
        {ctrl.inva, ctrl.cin} = 2'b11;
        cond_sel = C_SLT;
      end
      OPC_SLE: begin
        {ctrl.inva, ctrl.cin} = 2'b11;
        cond_sel = C_SLE;
      end
      OPC_SCO: begin
        ctrl.sign = 1'b0;
        cond_sel = C_SCO;
      end
      // branches test Rs alone: Rs + 0
      OPC_BEQZ: begin
        ctrl.bzero = 1'b1;
        cond_sel = C_BEQZ;
      end
      OPC_BNEZ: begin
        ctrl.bzero = 1'b1;
        cond_sel = C_BNEZ;
      end
      OPC_BLTZ: begin
        ctrl.bzero = 1'b1;
        cond_sel = C_BLTZ;
      end
      OPC_BGEZ: begin
        ctrl.bzero = 1'b1;
        cond_sel = C_BGEZ;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/ex_alu_ctrl.sv
// ex_alu_ctrl: execute stage driving a combinational 16-bit ALU through a two-stage valid/ready pipe
//  in_valid/in_ready/opcode/func : decode side; E1 registers the decoded ALU controls
//  alu_* outputs                 : straight from E1 registers
//  alu_out/alu_z/neg/cout/ofl    : ALU response, captured into E2
//  out_valid/out_ready/wb_data/br_taken : writeback side from E2
//  flush : kills both stages; ovf_sticky/ovf_clr : sticky signed ADD/SUB overflow
module ex_alu_ctrl
  import ex_pkg::*;
#(
  parameter int DW  = 16,
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] opcode,
  input  logic [1:0]     func,
  output logic [2:0]     alu_op,
  output logic           alu_inva,
  output logic           alu_invb,
  output logic           alu_cin,
  output logic           alu_sign,
  output logic           alu_bzero,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_z,
  input  logic           alu_neg,
  input  logic           alu_cout,
  input  logic           alu_ofl,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  wb_data,
  output logic           br_taken,
  output logic           ovf_sticky,
  input  logic           ovf_clr
);
  ctrl_t dec_ctrl, e1_ctrl;
  cond_e dec_cond, e1_cond;
  logic  e1_valid, e2_valid, e2_arith, e2_ofl, advance, accept, cond;
  ex_alu_decode u_dec (.opcode(opcode), .func(func), .ctrl(dec_ctrl), .cond_sel(dec_cond));
  assign advance = ~e2_valid | out_ready;
  assign in_ready = ~e1_valid | advance;
  assign accept = in_valid & in_ready & ~flush;
  assign {alu_op, alu_inva, alu_invb, alu_cin, alu_sign, alu_bzero} =
         {e1_ctrl.op, e1_ctrl.inva, e1_ctrl.invb, e1_ctrl.cin, e1_ctrl.sign, e1_ctrl.bzero};
  assign out_valid = e2_valid;
  always_comb begin
    cond = 1'b0;
    case (e1_cond)
      C_SEQ:  cond = alu_z;
      C_SLT:  cond = ~alu_z & ~(alu_neg ^ alu_ofl);
      C_SLE:  cond = ~(alu_neg ^ alu_ofl);
      C_SCO:  cond = alu_cout;
      C_BEQZ: cond = alu_z;
      C_BNEZ: cond = ~alu_z;
      C_BLTZ: cond = alu_neg;
      C_BGEZ: cond = ~alu_neg;
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_valid <= 1'b0;
      e1_ctrl  <= '0;
      e1_cond  <= C_NONE;
    end else begin
      if (flush) e1_valid <= 1'b0;
      else if (in_ready) e1_valid <= in_valid;
      if (accept) begin
        e1_ctrl <= dec_ctrl;
        e1_cond <= dec_cond;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e2_valid <= 1'b0;
      wb_data  <= '0;
      br_taken <= 1'b0;
      e2_arith <= 1'b0;
      e2_ofl   <= 1'b0;
    end else begin
      if (flush) e2_valid <= 1'b0;
      else if (advance) e2_valid <= e1_valid;
      if (advance & e1_valid) begin
        wb_data  <= is_set(e1_cond) ? {{(DW-1){1'b0}}, cond} : alu_out;
        br_taken <= is_br(e1_cond) & cond;
        e2_arith <= e1_ctrl.arith;
        e2_ofl   <= alu_ofl;
      end
    end
  end
  // overflow is recorded only as the result actually leaves E2; a set beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky <= 1'b0;
    else if (e2_valid & out_ready & e2_arith & e2_ofl) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end
endmodule
